// File: rtl/sd_resp_rx_if.sv
// CMD-line response receiver bus: sampling strobe, CMD line, request controls and decoded results.
interface sd_resp_rx_if;
  logic         sd_clk_rise;
  logic         cmd_in;
  logic         start;
  logic         long_resp;
  logic         crc_skip;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic         crc_err;
  logic         frame_err;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [127:0] resp_long;

  modport master (
    output sd_clk_rise, cmd_in, start, long_resp, crc_skip,
    input  busy, done, timeout_err, crc_err, frame_err, resp_index, resp_arg, resp_long
  );
  modport slave (
    input  sd_clk_rise, cmd_in, start, long_resp, crc_skip,
    output busy, done, timeout_err, crc_err, frame_err, resp_index, resp_arg, resp_long
  );
endinterface

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: 48/136-bit frames, CRC7 and framing checks, NCR timeout.
module sd_resp_rx #(
  parameter int NCR_MAX = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  sd_resp_rx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, CHECK} state_t;
  localparam int NW = $clog2(NCR_MAX + 1);

  state_t         state, state_nx;
  logic           is_long, skip, to_hit;
  logic [NW-1:0]  ncr;
  logic [7:0]     bcnt;
  logic [6:0]     crc;
  // Start bit is not stored; frame bit k sits at sr[k] once the frame is complete.
  logic [134:0]   sr;
  logic           done_q, to_q, cerr_q, ferr_q;
  logic [5:0]     idx_q;
  logic [31:0]    arg_q;
  logic [127:0]   long_q;

  logic stb, ncr_last, last_bit, crc_en;
  logic [7:0] flen;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
  endfunction

  assign stb      = bus.sd_clk_rise;
  assign flen     = is_long ? 8'd136 : 8'd48;
  assign ncr_last = (ncr == NW'(NCR_MAX - 1));
  assign last_bit = (bcnt == flen - 8'd1);
  // bcnt counts bits already taken, so the incoming bit is number bcnt+1.
  assign crc_en   = is_long ? (bcnt >= 8'd8 && bcnt <= 8'd127) : (bcnt <= 8'd39);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (bus.start) state_nx = WAIT_START;
      WAIT_START: if (stb) begin
                    if (!bus.cmd_in)   state_nx = RECV;
                    else if (ncr_last) state_nx = CHECK;
                  end
      RECV:       if (stb && last_bit) state_nx = CHECK;
      CHECK:      state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_long <= 1'b0; skip <= 1'b0; to_hit <= 1'b0;
      ncr <= '0; bcnt <= '0; crc <= '0; sr <= '0;
      done_q <= 1'b0; to_q <= 1'b0; cerr_q <= 1'b0; ferr_q <= 1'b0;
      idx_q <= '0; arg_q <= '0; long_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          is_long <= bus.long_resp;
          skip    <= bus.crc_skip;
          to_hit  <= 1'b0;
          to_q    <= 1'b0; cerr_q <= 1'b0; ferr_q <= 1'b0;
          ncr     <= '0; bcnt <= '0; crc <= '0;
        end
        WAIT_START: if (stb) begin
          if (!bus.cmd_in) begin
            bcnt <= 8'd1;
            crc  <= crc7_step(crc, 1'b0);
          end else begin
            ncr <= ncr + NW'(1);
            if (ncr_last) to_hit <= 1'b1;
          end
        end
        RECV: if (stb) begin
          sr   <= {sr[133:0], bus.cmd_in};
          bcnt <= bcnt + 8'd1;
          if (crc_en) crc <= crc7_step(crc, bus.cmd_in);
        end
        CHECK: begin
          done_q <= 1'b1;
          if (to_hit) to_q <= 1'b1;
          else begin
            ferr_q <= (is_long ? sr[134] : sr[46]) | ~sr[0];
            cerr_q <= ~skip & (sr[7:1] != crc);
            idx_q  <= is_long ? sr[133:128] : sr[45:40];
            if (is_long) long_q <= {sr[127:1], 1'b0};
            else         arg_q  <= sr[39:8];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.timeout_err = to_q;
  assign bus.crc_err     = cerr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.resp_index  = idx_q;
  assign bus.resp_arg    = arg_q;
  assign bus.resp_long   = long_q;
endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx with a frame-level reference model checked every cycle.
module tb_sd_resp_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_resp_rx_if bus();
  sd_resp_rx #(.NCR_MAX(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  logic         exp_busy = 0, exp_done = 0, exp_to = 0, exp_cerr = 0, exp_ferr = 0;
  logic [5:0]   exp_idx  = '0;
  logic [31:0]  exp_arg  = '0;
  logic [127:0] exp_long = '0;
  logic         cur_skip = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over v[msb:lsb].
  function automatic logic [6:0] crc_div(input logic [135:0] v, input int msb, input int lsb);
    logic [142:0] r;
    int n;
    n = msb - lsb + 1;
    r = '0;
    for (int i = 0; i < n; i++) r[n + 6 - i] = v[msb - i];
    for (int i = n + 6; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk_short(input logic tbit, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic eb);
    logic [135:0] f;
    f = '0;
    f[47:40] = {1'b0, tbit, idx};
    f[39:8]  = arg;
    f[7:1]   = crc_div(f, 47, 8);
    f[0]     = eb;
    return f;
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] cid);
    logic [135:0] f;
    f = '0;
    f[135:128] = 8'h3F;
    f[127:8]   = cid;
    f[7:1]     = crc_div(f, 127, 8);
    f[0]       = 1'b1;
    return f;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("busy",        128'(bus.busy),        128'(exp_busy));
    chk("done",        128'(bus.done),        128'(exp_done));
    chk("timeout_err", 128'(bus.timeout_err), 128'(exp_to));
    chk("crc_err",     128'(bus.crc_err),     128'(exp_cerr));
    chk("frame_err",   128'(bus.frame_err),   128'(exp_ferr));
    chk("resp_index",  128'(bus.resp_index),  128'(exp_idx));
    chk("resp_arg",    128'(bus.resp_arg),    128'(exp_arg));
    chk("resp_long",   bus.resp_long,         exp_long);
  end

  task automatic model_done(input logic [135:0] f, input int len);
    exp_done = 1; exp_busy = 0;
    exp_ferr = f[len-2] | ~f[0];
    exp_cerr = !cur_skip && (f[7:1] != crc_div(f, (len == 48) ? 47 : 127, 8));
    if (len == 48) begin
      exp_idx = f[45:40]; exp_arg = f[39:8];
    end else begin
      exp_idx = f[133:128]; exp_long = {f[127:1], 1'b0};
    end
  endtask

  task automatic do_start(input logic l, input logic s);
    bus.start = 1; bus.long_resp = l; bus.crc_skip = s;
    @(posedge clk); #1;
    bus.start = 0; bus.long_resp = ~l; bus.crc_skip = ~s;
    cur_skip = s;
    exp_busy = 1; exp_done = 0; exp_to = 0; exp_cerr = 0; exp_ferr = 0;
  endtask

  task automatic strobe(input logic b, input int sp);
    bus.sd_clk_rise = 1; bus.cmd_in = b;
    @(posedge clk); #1;
    bus.sd_clk_rise = 0; bus.cmd_in = 1;
    repeat (sp) begin @(posedge clk); #1; end
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    exp_done = 0;
  endtask

  // Leaves the bench in the done cycle with expectations updated.
  task automatic send_frame(input int nhigh, input int sp, input logic [135:0] f, input int len);
    for (int i = 0; i < nhigh; i++) strobe(1'b1, sp);
    for (int i = len - 1; i >= 0; i--) strobe(f[i], (i == 0) ? 0 : sp);
    bus.sd_clk_rise = 1; bus.cmd_in = 0;  // stray strobe while checking
    @(posedge clk); #1;
    bus.sd_clk_rise = 0; bus.cmd_in = 1;
    model_done(f, len);
  endtask

  logic [135:0] f7, f3, fl, fl2, fe, ft, pv;
  logic [119:0] cid;

  initial begin
    bus.sd_clk_rise = 0; bus.cmd_in = 1; bus.start = 0; bus.long_resp = 0; bus.crc_skip = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    pv = '0; pv[39:0] = 40'h40_0000_0000;
    chk("model_crc_cmd0", 128'(crc_div(pv, 39, 0)), 128'(7'h4A));
    pv = '0; pv[39:0] = 40'h48_0000_01AA;
    chk("model_crc_cmd8", 128'(crc_div(pv, 39, 0)), 128'(7'h43));

    // R7
    f7 = mk_short(1'b0, 6'h08, 32'h0000_01AA, 1'b1);
    do_start(0, 0);
    send_frame(5, 0, f7, 48);
    chk("r7_index", 128'(bus.resp_index), 128'(6'h08));
    chk("r7_arg",   128'(bus.resp_arg),   128'(32'h0000_01AA));
    chk("r7_errs",  128'({bus.crc_err, bus.frame_err, bus.timeout_err}), 128'(3'b000));
    idle1();
    repeat (3) strobe(1'b0, 0);  // strobes in idle are ignored

    // R3 with CRC skipped, then again with check, started in the done cycle
    f3 = mk_short(1'b0, 6'h3F, 32'h80FF_8000, 1'b1);
    f3[7:1] = 7'h7F;
    do_start(0, 1);
    send_frame(3, 1, f3, 48);
    chk("r3_skip_crc", 128'(bus.crc_err),  128'(1'b0));
    chk("r3_arg",      128'(bus.resp_arg), 128'(32'h80FF_8000));
    do_start(0, 0);
    send_frame(2, 0, f3, 48);
    chk("r3_nocheck_crc", 128'(bus.crc_err), 128'(1'b1));
    idle1();

    // R2, good then one CID bit flipped, with an ignored start while busy
    cid = 120'h0353_4453_4433_3280_1234_5678_0123_45;
    fl = mk_long(cid);
    do_start(1, 0);
    send_frame(4, 0, fl, 136);
    chk("r2_cid",   bus.resp_long[127:8], 128'(cid));
    chk("r2_crc",   128'(bus.crc_err),    128'(1'b0));
    chk("r2_index", 128'(bus.resp_index), 128'(6'h3F));
    idle1();
    fl2 = fl; fl2[60] = ~fl2[60];
    do_start(1, 0);
    bus.start = 1; bus.long_resp = 0; bus.crc_skip = 1;
    @(posedge clk); #1;
    bus.start = 0;
    send_frame(1, 2, fl2, 136);
    chk("r2_flip_crc", 128'(bus.crc_err), 128'(1'b1));
    idle1();

    // Timeout
    do_start(0, 0);
    for (int i = 0; i < 64; i++) strobe(1'b1, (i == 63) ? 0 : (i % 2));
    @(posedge clk); #1;
    exp_done = 1; exp_busy = 0; exp_to = 1;
    chk("to_flag",   128'(bus.timeout_err), 128'(1'b1));
    chk("to_arg",    128'(bus.resp_arg),    128'(32'h80FF_8000));
    chk("to_crcerr", 128'(bus.crc_err),     128'(1'b0));
    idle1();

    // Frame errors
    fe = mk_short(1'b0, 6'h08, 32'h1234_5678, 1'b0);
    do_start(0, 0);
    send_frame(0, 0, fe, 48);
    chk("ferr_end", 128'(bus.frame_err), 128'(1'b1));
    idle1();
    ft = mk_short(1'b1, 6'h11, 32'hCAFE_F00D, 1'b1);
    do_start(0, 0);
    send_frame(2, 0, ft, 48);
    chk("ferr_tbit", 128'(bus.frame_err), 128'(1'b1));
    chk("ferr_tbit_crc", 128'(bus.crc_err), 128'(1'b0));
    idle1();

    // Reset mid-frame
    do_start(0, 0);
    strobe(1'b1, 0); strobe(1'b1, 0);
    for (int i = 47; i >= 28; i--) strobe(f7[i], 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    exp_busy = 0; exp_done = 0; exp_to = 0; exp_cerr = 0; exp_ferr = 0;
    exp_idx = '0; exp_arg = '0; exp_long = '0;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_arg", 128'(bus.resp_arg), 128'(32'h0));
    do_start(0, 0);
    bus.start = 1; bus.long_resp = 1;
    @(posedge clk); #1;
    bus.start = 0;
    send_frame(1, 0, f7, 48);
    chk("post_rst_arg", 128'(bus.resp_arg),   128'(32'h0000_01AA));
    chk("post_rst_idx", 128'(bus.resp_index), 128'(6'h08));
    idle1();
    repeat (2) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
